tft_fb_responder: RTL and testbench



---
 rtl/tft_fb_pkg.sv | 18 +
 rtl/tft_fb_responder_if.sv | 26 ++
 rtl/fb_ram.sv | 22 ++
 rtl/tft_fb_responder.sv | 130 +++++++++++++
 tb/tb_tft_fb_responder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/tft_fb_pkg.sv
// rtl/tft_fb_pkg.sv - shared types, defaults and address helper for the framebuffer responder
package tft_fb_pkg;

    typedef enum logic [1:0] {IDLE, ACK, READ} resp_state_t;

    localparam int FB_RAMAN = 12;
    localparam int FB_BURST = 8;

    // Sum of base and offset truncated to aw bits, so bursts wrap around the top of the framebuffer.
    function automatic logic [31:0] fb_wrap_add(input logic [31:0] base,
                                                input logic [31:0] offset,
                                                input int unsigned aw);
        logic [31:0] mask;
        mask = (32'd1 << aw) - 32'd1;
        return (base + offset) & mask;
    endfunction

endpackage

// File: rtl/tft_fb_responder_if.sv
// rtl/tft_fb_responder_if.sv - fetch and pixel-write bus between display side and responder
interface tft_fb_responder_if #(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int RAMAN = 12
);
    logic             req;
    logic [AN-1:0]    req_addr;
    logic             req_ack;
    logic [DN-1:0]    mem_data;
    logic             mem_valid;
    logic             wr_en;
    logic [RAMAN-1:0] wr_addr;
    logic [DN-1:0]    wr_data;
    logic             busy;

    modport master (
        output req, req_addr, wr_en, wr_addr, wr_data,
        input  req_ack, mem_data, mem_valid, busy
    );

    modport slave (
        input  req, req_addr, wr_en, wr_addr, wr_data,
        output req_ack, mem_data, mem_valid, busy
    );
endinterface

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - single-port synchronous framebuffer RAM, one-cycle read latency
module fb_ram #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // No-change mode: a write cycle leaves rdata untouched.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/tft_fb_responder.sv
// rtl/tft_fb_responder.sv - burst fetch responder over an on-chip framebuffer RAM
// Optional TFT_FB_RESPONDER_STATS_EN adds saturating burst/stall counters.
module tft_fb_responder
    import tft_fb_pkg::*;
#(
    parameter int AN    = 24,
    parameter int DN    = 16,
    parameter int BURST = FB_BURST,
    parameter int RAMAN = FB_RAMAN
) (
    input  logic clkSYS,
    input  logic reset,
    tft_fb_responder_if.slave bus
`ifdef TFT_FB_RESPONDER_STATS_EN
    ,
    output logic [15:0] stat_bursts,
    output logic [15:0] stat_stalls
`endif
);
    localparam int OW = (BURST > 1) ? $clog2(BURST) : 1;

    resp_state_t      state, state_next;
    logic [RAMAN-1:0] base;
    logic [RAMAN-1:0] rd_addr;
    logic [RAMAN-1:0] ram_addr;
    logic [OW-1:0]    offset;
    logic             req_ack_q;
    logic             issue_q;
    logic             latch_req;
    logic             issue;
    logic             stall;
    logic [DN-1:0]    ram_rdata;

    always_comb begin
        state_next = state;
        latch_req  = 1'b0;
        issue      = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    latch_req  = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                state_next = READ;
            end
            READ: begin
                // The pixel write port owns the single RAM port; the read retries next cycle.
                if (bus.wr_en) begin
                    stall = 1'b1;
                end else begin
                    issue = 1'b1;
                    if (offset == OW'(BURST - 1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkSYS) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clkSYS) begin
        if (reset) begin
            base      <= '0;
            offset    <= '0;
            req_ack_q <= 1'b0;
            issue_q   <= 1'b0;
        end else begin
            req_ack_q <= latch_req;
            issue_q   <= issue;
            if (latch_req) begin
                base <= bus.req_addr[RAMAN-1:0];
            end
            if (state == ACK) begin
                offset <= '0;
            end else if (issue) begin
                offset <= offset + OW'(1);
            end
        end
    end

    assign rd_addr  = RAMAN'(fb_wrap_add(32'(base), 32'(offset), RAMAN));
    assign ram_addr = bus.wr_en ? bus.wr_addr : rd_addr;

    fb_ram #(
        .AW(RAMAN),
        .DW(DN)
    ) u_ram (
        .clk   (clkSYS),
        .we    (bus.wr_en),
        .addr  (ram_addr),
        .wdata (bus.wr_data),
        .rdata (ram_rdata)
    );

    // RAM output is only meaningful the cycle after an issue; hold zero otherwise.
    assign bus.req_ack   = req_ack_q;
    assign bus.mem_valid = issue_q;
    assign bus.mem_data  = issue_q ? ram_rdata : '0;
    assign bus.busy      = (state != IDLE);

`ifdef TFT_FB_RESPONDER_STATS_EN
    always_ff @(posedge clkSYS) begin
        if (reset) begin
            stat_bursts <= '0;
            stat_stalls <= '0;
        end else begin
            if (req_ack_q && (stat_bursts != 16'hFFFF)) begin
                stat_bursts <= stat_bursts + 16'd1;
            end
            if (stall && (stat_stalls != 16'hFFFF)) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tft_fb_responder.sv
// tb/tb_tft_fb_responder.sv - directed self-checking bench for tft_fb_responder
module tb_tft_fb_responder;

    logic clkSYS;
    logic reset;

    tft_fb_responder_if #(.AN(24), .DN(16), .RAMAN(12)) bus ();

`ifdef TFT_FB_RESPONDER_STATS_EN
    logic [15:0] stat_bursts;
    logic [15:0] stat_stalls;
`endif

    tft_fb_responder #(
        .AN(24), .DN(16), .BURST(8), .RAMAN(12)
    ) dut (
        .clkSYS (clkSYS),
        .reset  (reset),
        .bus    (bus)
`ifdef TFT_FB_RESPONDER_STATS_EN
        ,
        .stat_bursts (stat_bursts),
        .stat_stalls (stat_stalls)
`endif
    );

    initial clkSYS = 1'b0;
    always #5 clkSYS = ~clkSYS;

    int n_cmp;
    int n_bad;
    logic [15:0] got   [0:31];
    int          val_t [0:31];
    int          ack_t [0:3];
    int          n_acks;
    int          n_valid;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkSYS);
        #1;
    endtask

    // Runs nb bursts (requester adds 8 on each ack); writes wd to wa on READ cycles c1/c2 of the
    // first burst (0 = none); stops early once abort_n words have been seen (0 = never).
    task automatic run_burst(input logic [23:0] addr, input int nb, input int c1, input int c2,
                             input logic [11:0] wa, input logic [15:0] wd, input int abort_n);
        int t;
        int limit;
        t       = 0;
        n_acks  = 0;
        n_valid = 0;
        limit   = (abort_n > 0) ? abort_n : nb * 8;
        bus.req_addr = addr;
        bus.req      = 1'b1;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        while (n_valid < limit && t < 40 * nb) begin
            tick();
            t++;
            if (bus.req_ack) begin
                ack_t[n_acks] = t;
                n_acks++;
                bus.req_addr = bus.req_addr + 24'd8;
                if (n_acks == nb) bus.req = 1'b0;
            end
            if (bus.mem_valid) begin
                got[n_valid]   = bus.mem_data;
                val_t[n_valid] = t;
                n_valid++;
            end
            bus.wr_en = (n_acks > 0) && (c1 > 0) && ((t == ack_t[0] + c1) || (t == ack_t[0] + c2));
        end
        bus.wr_en = 1'b0;
        bus.req   = 1'b0;
        check_eq("burst_word_count", n_valid, limit);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        n_cmp = 0;
        n_bad = 0;
        bus.req      = 1'b0;
        bus.req_addr = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        reset        = 1'b1;
        tick();
        tick();
        check_eq("rst_req_ack",   bus.req_ack,   0);
        check_eq("rst_mem_valid", bus.mem_valid, 0);
        check_eq("rst_mem_data",  bus.mem_data,  0);
        check_eq("rst_busy",      bus.busy,      0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 4096; k++) begin
            if (k < 'h60 || k >= 'hFF0) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 12'(k);
                bus.wr_data = 16'h1000 + 16'(k);
                tick();
            end
        end
        bus.wr_en = 1'b0;
        tick();

        // Single burst from 0x40
        run_burst(24'h000040, 1, 0, 0, 12'h0, 16'h0, 0);
        check_eq("b1_acks", n_acks, 1);
        check_eq("b1_first_latency", val_t[0] - ack_t[0], 2);
        check_eq("b1_contiguous", val_t[7] - val_t[0], 7);
        for (int i = 0; i < 8; i++) check_eq("b1_word", got[i], 16'h1040 + 16'(i));
        tick();
        check_eq("b1_idle_busy", bus.busy, 0);

        // Three back-to-back bursts with req held
        run_burst(24'h000000, 3, 0, 0, 12'h0, 16'h0, 0);
        check_eq("b2b_acks", n_acks, 3);
        check_eq("b2b_ack_gap1", ack_t[1] - ack_t[0] - 1, 9);
        check_eq("b2b_ack_gap2", ack_t[2] - ack_t[1] - 1, 9);
        for (int i = 0; i < 24; i++) check_eq("b2b_word", got[i], 16'h1000 + 16'(i));
        tick();

        // Wrap across the top of the framebuffer
        run_burst(24'h000FFE, 1, 0, 0, 12'h0, 16'h0, 0);
        check_eq("wrap_w0", got[0], 16'h1FFE);
        check_eq("wrap_w1", got[1], 16'h1FFF);
        for (int i = 2; i < 8; i++) check_eq("wrap_w", got[i], 16'h1000 + 16'(i - 2));
        tick();

        // Reset on the 3rd returned word
        run_burst(24'h000010, 1, 0, 0, 12'h0, 16'h0, 3);
        check_eq("abort_w2", got[2], 16'h1012);
        reset = 1'b1;
        tick();
        check_eq("abort_mem_valid", bus.mem_valid, 0);
        check_eq("abort_req_ack",   bus.req_ack,   0);
        check_eq("abort_busy",      bus.busy,      0);
        reset = 1'b0;
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mem_valid || bus.busy) quiet++;
        end
        check_eq("abort_quiet", quiet, 0);
        run_burst(24'hA50020, 1, 0, 0, 12'h0, 16'h0, 0);
        check_eq("restart_latency", val_t[0] - ack_t[0], 2);
        check_eq("restart_w0", got[0], 16'h1020);
        check_eq("restart_w7", got[7], 16'h1027);
        tick();

        // Write stalls during READ, run twice from a fresh reset
        do_reset();
        tick();
        for (int r = 0; r < 2; r++) begin
            run_burst(24'h000050, 1, 2, 4, 12'h055, 16'hBEEF, 0);
            check_eq("wr_first_latency", val_t[0] - ack_t[0], 2);
            check_eq("wr_gaps", val_t[7] - val_t[0] + 1 - 8, 2);
            check_eq("wr_w0", got[0], 16'h1050);
            check_eq("wr_w4", got[4], 16'h1054);
            check_eq("wr_w5", got[5], 16'hBEEF);
            check_eq("wr_w7", got[7], 16'h1057);
            tick();
        end
`ifdef TFT_FB_RESPONDER_STATS_EN
        check_eq("stat_bursts", stat_bursts, 16'd2);
        check_eq("stat_stalls", stat_stalls, 16'd4);
        reset = 1'b1;
        tick();
        check_eq("stat_bursts_rst", stat_bursts, 16'd0);
        check_eq("stat_stalls_rst", stat_stalls, 16'd0);
        reset = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
